// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 32-bit pseudo-random noise stream: self-syncs,
// then flywheels its own prediction and keeps saturating error statistics.
module lfsr_stream_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_ERR = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [5:0]       err_bits,
  output logic [31:0]      exp_data,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_word_cnt,
  output logic [CNT_W-1:0] err_bit_cnt
);

  localparam int MCW = $clog2(LOCK_CNT + 1);
  localparam int MW  = $clog2(UNLOCK_ERR + 1);
  // Adder wide enough for both the counter and a 6-bit popcount plus carry.
  localparam int SW  = ((CNT_W > 6) ? CNT_W : 6) + 1;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  function automatic logic [31:0] step(input logic [31:0] w);
    return {w[30:0], w[0] ^ w[1] ^ w[2] ^ w[22] ^ 1'b1};
  endfunction

  function automatic logic [5:0] popcnt(input logic [31:0] v);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 32; i++) s = s + {5'b0, v[i]};
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [5:0]       p);
    logic [SW-1:0] s;
    s = SW'(c) + SW'(p);
    if (s > SW'({CNT_W{1'b1}})) return '1;
    return s[CNT_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      exp_q, exp_d;
  logic [MCW-1:0]   match_q, match_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             pulse_q, pulse_d;
  logic [5:0]       bits_q, bits_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] ewcnt_q, ewcnt_d;
  logic [CNT_W-1:0] ebcnt_q, ebcnt_d;

  logic [31:0]    diff;
  logic [5:0]     pop;
  logic           hit;
  logic [MCW-1:0] match_inc;
  logic [MW-1:0]  miss_inc;

  assign diff      = in_data ^ exp_q;
  assign pop       = popcnt(diff);
  assign hit       = (diff == 32'h0);
  assign match_inc = match_q + MCW'(1);
  assign miss_inc  = miss_q + MW'(1);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    pulse_d = 1'b0;
    bits_d  = bits_q;
    wcnt_d  = wcnt_q;
    ewcnt_d = ewcnt_q;
    ebcnt_d = ebcnt_q;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          // The all-ones word is a fixed point of step(); seeding on it would never resync.
          if (in_data != 32'hFFFF_FFFF) begin
            exp_d   = step(in_data);
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            match_d = match_inc;
            exp_d   = step(in_data);
            if (match_inc == MCW'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (in_data == 32'hFFFF_FFFF) begin
            match_d = '0;
            state_d = HUNT;
          end else begin
            exp_d   = step(in_data);
            match_d = '0;
          end
        end
        LOCKED: begin
          exp_d  = step(exp_q);
          wcnt_d = sat_inc(wcnt_q);
          if (hit) begin
            miss_d = '0;
            bits_d = '0;
          end else begin
            pulse_d = 1'b1;
            bits_d  = pop;
            ewcnt_d = sat_inc(ewcnt_q);
            ebcnt_d = sat_add(ebcnt_q, pop);
            miss_d  = miss_inc;
            if (miss_inc == MW'(UNLOCK_ERR)) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (clear) begin
      wcnt_d  = '0;
      ewcnt_d = '0;
      ebcnt_d = '0;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= HUNT;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      bits_q   <= '0;
      wcnt_q   <= '0;
      ewcnt_q  <= '0;
      ebcnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      bits_q   <= bits_d;
      wcnt_q   <= wcnt_d;
      ewcnt_q  <= ewcnt_d;
      ebcnt_q  <= ebcnt_d;
    end
  end

  assign locked       = locked_q;
  assign err_pulse    = pulse_q;
  assign err_bits     = bits_q;
  assign exp_data     = exp_q;
  assign word_cnt     = wcnt_q;
  assign err_word_cnt = ewcnt_q;
  assign err_bit_cnt  = ebcnt_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench: default-parameter checker plus a narrow-counter instance for saturation.
module tb_lfsr_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, in_valid, clear;
  logic [31:0] in_data;

  logic        a_locked, a_pulse;
  logic [5:0]  a_bits;
  logic [31:0] a_exp, a_wc, a_ewc, a_ebc;

  logic        b_locked, b_pulse;
  logic [5:0]  b_bits;
  logic [31:0] b_exp;
  logic [3:0]  b_wc, b_ewc, b_ebc;

  lfsr_stream_checker #(.LOCK_CNT(4), .UNLOCK_ERR(8), .CNT_W(32)) u_a (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(a_locked), .err_pulse(a_pulse), .err_bits(a_bits), .exp_data(a_exp),
    .word_cnt(a_wc), .err_word_cnt(a_ewc), .err_bit_cnt(a_ebc));

  lfsr_stream_checker #(.LOCK_CNT(4), .UNLOCK_ERR(32), .CNT_W(4)) u_b (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(b_locked), .err_pulse(b_pulse), .err_bits(b_bits), .exp_data(b_exp),
    .word_cnt(b_wc), .err_word_cnt(b_ewc), .err_bit_cnt(b_ebc));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] w);
    return {w[30:0], w[0] ^ w[1] ^ w[2] ^ w[22] ^ 1'b1};
  endfunction

  // Called at a negedge; returns at the next negedge with the word's result visible.
  task automatic word(input logic v, input logic [31:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic relock(input string tag);
    word(1'b1, 32'h1, 1'b0);
    check({tag, "_hunt_lock"}, 32'(a_locked), 32'd0);
    word(1'b1, 32'h2, 1'b0);
    word(1'b1, 32'h4, 1'b0);
    word(1'b1, 32'h8, 1'b0);
    check({tag, "_v3_lock"}, 32'(a_locked), 32'd0);
    word(1'b1, 32'h11, 1'b0);
    check({tag, "_locked"}, 32'(a_locked), 32'd1);
    check({tag, "_exp"}, a_exp, 32'h22);
  endtask

  logic [31:0] e;
  int          eb;
  int          last_pop;

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clear    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_locked", 32'(a_locked), 32'd0);
    check("rst_exp", a_exp, 32'h0);
    check("rst_pulse", 32'(a_pulse), 32'd0);
    check("rst_bits", 32'(a_bits), 32'd0);
    check("rst_wc", a_wc, 32'd0);
    check("rst_b_ewc", 32'(b_ewc), 32'd0);
    resetn = 1'b1;

    // Lock acquisition
    relock("acq");
    check("acq_wc", a_wc, 32'd0);

    // Flywheel error
    word(1'b1, 32'h22, 1'b0);
    check("fly_ok_pulse", 32'(a_pulse), 32'd0);
    check("fly_ok_exp", a_exp, 32'h44);
    word(1'b1, 32'h41, 1'b0);
    check("fly_err_pulse", 32'(a_pulse), 32'd1);
    check("fly_err_bits", 32'(a_bits), 32'd2);
    check("fly_err_ewc", a_ewc, 32'd1);
    check("fly_err_ebc", a_ebc, 32'd2);
    check("fly_err_locked", 32'(a_locked), 32'd1);
    check("fly_err_exp", a_exp, 32'h88);
    word(1'b1, 32'h88, 1'b0);
    check("fly_88_pulse", 32'(a_pulse), 32'd0);
    check("fly_88_bits", 32'(a_bits), 32'd0);
    word(1'b1, 32'h111, 1'b0);
    check("fly_wc", a_wc, 32'd4);
    check("fly_ewc", a_ewc, 32'd1);
    check("fly_exp", a_exp, 32'h222);
    e = 32'h222;

    // clear on an idle cycle keeps lock
    word(1'b0, 32'h0, 1'b1);
    check("clr_wc", a_wc, 32'd0);
    check("clr_ewc", a_ewc, 32'd0);
    check("clr_ebc", a_ebc, 32'd0);
    check("clr_locked", 32'(a_locked), 32'd1);
    check("clr_exp", a_exp, e);

    // Loss of lock A: 7 misses then a good word
    eb = 0;
    last_pop = 0;
    for (int i = 0; i < 7; i++) begin
      last_pop = $countones(e);
      eb += last_pop;
      word(1'b1, 32'h0, 1'b0);
      e = nxt(e);
    end
    check("miss7_ewc", a_ewc, 32'd7);
    check("miss7_ebc", a_ebc, 32'(eb));
    check("miss7_bits", 32'(a_bits), 32'(last_pop));
    check("miss7_locked", 32'(a_locked), 32'd1);
    word(1'b1, e, 1'b0);
    e = nxt(e);
    check("recover_pulse", 32'(a_pulse), 32'd0);
    check("recover_bits", 32'(a_bits), 32'd0);
    check("recover_locked", 32'(a_locked), 32'd1);

    // Loss of lock B: 8 consecutive misses
    for (int i = 0; i < 8; i++) begin
      word(1'b1, 32'h0, 1'b0);
      e = nxt(e);
      if (i == 6) check("miss_b7_locked", 32'(a_locked), 32'd1);
    end
    check("unlock_locked", 32'(a_locked), 32'd0);
    check("unlock_ewc", a_ewc, 32'd15);
    check("unlock_wc", a_wc, 32'd16);

    // Lock-up word ignored in HUNT
    word(1'b1, 32'hFFFF_FFFF, 1'b0);
    check("lockup_locked", 32'(a_locked), 32'd0);
    check("lockup_exp", a_exp, e);
    relock("relock1");
    e = 32'h22;

    // Gaps while locked
    for (int i = 0; i < 10; i++) begin
      int gaps;
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        word(1'b0, 32'hDEAD_BEEF, 1'b0);
        check("gap_pulse", 32'(a_pulse), 32'd0);
        check("gap_exp", a_exp, e);
      end
      word(1'b1, e, 1'b0);
      e = nxt(e);
      check("gap_word_pulse", 32'(a_pulse), 32'd0);
    end
    check("gap_locked", 32'(a_locked), 32'd1);
    check("gap_wc", a_wc, 32'd26);
    check("gap_ewc", a_ewc, 32'd15);

    // Reset mid-operation
    resetn = 1'b0;
    word(1'b0, 32'h0, 1'b0);
    resetn = 1'b1;
    check("mrst_locked", 32'(a_locked), 32'd0);
    check("mrst_exp", a_exp, 32'h0);
    check("mrst_wc", a_wc, 32'd0);
    check("mrst_ewc", a_ewc, 32'd0);
    check("mrst_ebc", a_ebc, 32'd0);
    check("mrst_bits", 32'(a_bits), 32'd0);
    relock("relock2");
    check("sat_b_locked0", 32'(b_locked), 32'd1);

    // Saturation on the narrow-counter instance
    for (int i = 0; i < 20; i++) begin
      word(1'b1, 32'h0, 1'b0);
      if (i == 14) check("sat_b_ewc15", 32'(b_ewc), 32'd15);
    end
    check("sat_b_ewc", 32'(b_ewc), 32'd15);
    check("sat_b_wc", 32'(b_wc), 32'd15);
    check("sat_b_ebc", 32'(b_ebc), 32'd15);
    check("sat_b_locked", 32'(b_locked), 32'd1);
    word(1'b1, 32'h0, 1'b1);
    check("clr_b_ewc", 32'(b_ewc), 32'd0);
    check("clr_b_wc", 32'(b_wc), 32'd0);
    check("clr_b_ebc", 32'(b_ebc), 32'd0);
    check("clr_b_locked", 32'(b_locked), 32'd1);
    check("clr_b_pulse", 32'(b_pulse), 32'd1);
    word(1'b1, 32'h0, 1'b0);
    check("post_clr_b_ewc", 32'(b_ewc), 32'd1);
    check("post_clr_b_wc", 32'(b_wc), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
